dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder: the target side of the load/store handshake that the execute stage drives. The execute stage stalls until it sees mem_ready.
- Holds a word-organised RAM with byte-lane writes.
- Adds a programmable number of wait states.
- Flags accesses that fall outside its address window.
- Sits between the core's data port and the bus; each request gets exactly one mem_ready pulse.

Parameters:
- BASE_ADDR, 32'h00010000, byte base address of the RAM window.
- DEPTH, 4096, RAM size in 32-bit words; must be a power of two.
- WAIT_STATES, 0, extra cycles between request acceptance and response; legal range 0..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- mem_valid  in  1  request present; the initiator holds it and all request fields stable until mem_ready.
- mem_instr  in  1  instruction-fetch qualifier; ignored, no effect on behaviour.
- mem_addr  in  32  byte address; bits [1:0] are ignored (word access).
- mem_wdata  in  32  store data, already lane-aligned by the initiator.
- mem_wstrb  in  4  byte enables; 0 means read, nonzero means store.
- mem_rdata  out  32  read data; meaningful only while mem_ready=1.
- mem_ready  out  1  one-cycle response pulse.
- mem_error  out  1  asserted together with mem_ready when the address is out of range.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE; mem_ready=0, mem_error=0, mem_rdata=0; wait counter=0.
  - RAM contents are not cleared.
  - Reset mid-operation drops any pending request with no write performed; the response pulse is suppressed.
- Address decode: hit when (mem_addr - BASE_ADDR) < DEPTH*4, using unsigned 32-bit subtraction. Word index = (mem_addr - BASE_ADDR)[log2(DEPTH)+1:2].
- State machine:
  - IDLE: if mem_valid=1, latch addr, wdata, wstrb and hit. Go to WAIT with cnt=WAIT_STATES, or straight to ACCESS when WAIT_STATES=0.
  - WAIT: cnt decrements each cycle. When cnt reaches 1, go to ACCESS. If mem_valid=0 in any WAIT cycle, abort to IDLE with no write and no mem_ready.
  - ACCESS, one cycle:
    - if mem_valid=0, abort to IDLE as in WAIT;
    - otherwise, for a hit with wstrb!=0, write the enabled byte lanes;
    - for a hit read, register the RAM word into mem_rdata;
    - set mem_ready=1 (registered) and mem_error=!hit; go to RESP.
  - RESP: mem_ready=1 for this cycle only. mem_rdata holds the read word; it is 0 for a store or a miss. Next state is IDLE.
- mem_valid in the RESP cycle belongs to the completing request and is never re-accepted. A new request is sampled in IDLE, the cycle after RESP.
- Latency: from the valid-sampled edge to mem_ready is 2+WAIT_STATES cycles. The minimum request-to-request spacing is 3+WAIT_STATES cycles.
- Stores:
  - A partial wstrb leaves the unselected bytes unchanged.
  - A store to a miss writes nothing and returns mem_error=1.
- Reads of a miss return mem_rdata=0 and mem_error=1.
- mem_error, mem_rdata and mem_ready are all 0 outside RESP.
- Write-then-read of the same word on back-to-back requests returns the new data; the write completes in ACCESS, before the next IDLE sample.
- Address wrap: mem_addr below BASE_ADDR underflows in the subtraction and is therefore a miss.

Test Plan:
- Reset, then read: write 32'hDEADBEEF to BASE_ADDR with wstrb=4'hF, then read BASE_ADDR. Required: the read's mem_ready comes exactly 2 cycles after valid is sampled, with mem_rdata=32'hDEADBEEF and mem_error=0.
- Byte strobes:
  - store 32'h11223344 with wstrb=4'hF;
  - store 32'hAA00_0000 with wstrb=4'h8;
  - store 32'h0000_BB00 with wstrb=4'h2;
  - read: required mem_rdata=32'hAA22BB44.
- Wait states: with WAIT_STATES=3, a read asserts mem_ready 5 cycles after acceptance, pulse width exactly 1. mem_valid held high continuously across two requests yields exactly two pulses, 6 cycles apart.
- Out of range:
  - read at BASE_ADDR+DEPTH*4: mem_ready with mem_error=1 and mem_rdata=0;
  - store to BASE_ADDR-4: mem_error=1, and a later read of the last word shows its previous value unchanged.
- Abort: with WAIT_STATES=2, issue a store of 32'h55 to word 5 and drop mem_valid in the first WAIT cycle. Required: no mem_ready, and a subsequent read of word 5 returns its prior value.
- Reset mid-request: assert rst=0 during WAIT. Required: mem_ready stays 0 and the RAM is untouched. After release, a read completes normally with 2+WAIT_STATES latency.

Source files
------------

// File: rtl/dmem_if.sv
// Load/store handshake between the core's data port (master) and a memory target (slave).
interface dmem_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_error;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready, mem_error
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready, mem_error
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM behind the load/store handshake, with byte-lane stores,
// programmable wait states and out-of-window error responses.
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h00010000,
  parameter int          DEPTH       = 4096,
  parameter int          WAIT_STATES = 0
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);

  localparam int          AW        = $clog2(DEPTH);
  localparam logic [31:0] WIN_BYTES = 32'(DEPTH * 4);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [31:0]     offset;
  logic            addr_hit;
  logic [AW-1:0]   req_idx;
  logic [31:0]     req_wdata;
  logic [3:0]      req_wstrb;
  logic            req_hit;
  logic            do_write;
  logic            resp_ready;
  logic            resp_error;
  logic [31:0]     resp_rdata;
  logic [31:0]     ram [DEPTH];

  // Addresses below the base wrap to huge offsets and fall out of the window.
  assign offset   = bus.mem_addr - BASE_ADDR;
  assign addr_hit = offset < WIN_BYTES;

  logic unused_bits;
  assign unused_bits = ^{bus.mem_instr, offset[1:0], offset[31:AW+2]};

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.mem_valid) begin
      req_idx   <= offset[AW+1:2];
      req_wdata <= bus.mem_wdata;
      req_wstrb <= bus.mem_wstrb;
      req_hit   <= addr_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_ready <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mem_valid) begin
            if (WAIT_STATES == 0) begin
              state <= ACCESS;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_STATES);
            end
          end
        end
        WAIT: begin
          if (!bus.mem_valid) begin
            state <= IDLE;
          end else if (cnt == 4'd1) begin
            state <= ACCESS;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACCESS: begin
          if (!bus.mem_valid) begin
            state <= IDLE;
          end else begin
            state      <= RESP;
            resp_ready <= 1'b1;
            resp_error <= !req_hit;
            resp_rdata <= (req_hit && req_wstrb == 4'h0) ? ram[req_idx] : '0;
          end
        end
        RESP: begin
          // The valid still seen here belongs to the completing request.
          state      <= IDLE;
          resp_ready <= 1'b0;
          resp_error <= 1'b0;
          resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A reset landing on the ACCESS cycle must also cancel the store.
  assign do_write = rst && state == ACCESS && bus.mem_valid && req_hit && req_wstrb != 4'h0;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wstrb[b]) ram[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  assign bus.mem_ready = resp_ready;
  assign bus.mem_error = resp_error;
  assign bus.mem_rdata = resp_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with 0, 3 and 2 wait states.
module tb_dmem_responder;

  localparam logic [31:0] B = 32'h00010000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        v   [3];
  logic        ins [3];
  logic [31:0] ad  [3];
  logic [31:0] wd  [3];
  logic [3:0]  st  [3];
  logic        rdy [3];
  logic        err [3];
  logic [31:0] rdat[3];

  int checks = 0;
  int errors = 0;

  dmem_if bus0 ();
  dmem_if bus1 ();
  dmem_if bus2 ();

  assign bus0.mem_valid = v[0];  assign bus0.mem_instr = ins[0];
  assign bus0.mem_addr  = ad[0]; assign bus0.mem_wdata = wd[0];
  assign bus0.mem_wstrb = st[0];
  assign rdy[0] = bus0.mem_ready; assign err[0] = bus0.mem_error; assign rdat[0] = bus0.mem_rdata;

  assign bus1.mem_valid = v[1];  assign bus1.mem_instr = ins[1];
  assign bus1.mem_addr  = ad[1]; assign bus1.mem_wdata = wd[1];
  assign bus1.mem_wstrb = st[1];
  assign rdy[1] = bus1.mem_ready; assign err[1] = bus1.mem_error; assign rdat[1] = bus1.mem_rdata;

  assign bus2.mem_valid = v[2];  assign bus2.mem_instr = ins[2];
  assign bus2.mem_addr  = ad[2]; assign bus2.mem_wdata = wd[2];
  assign bus2.mem_wstrb = st[2];
  assign rdy[2] = bus2.mem_ready; assign err[2] = bus2.mem_error; assign rdat[2] = bus2.mem_rdata;

  dmem_responder #(.BASE_ADDR(B), .DEPTH(4096), .WAIT_STATES(0)) u_ws0 (.clk(clk), .rst(rst), .bus(bus0));
  dmem_responder #(.BASE_ADDR(B), .DEPTH(4096), .WAIT_STATES(3)) u_ws3 (.clk(clk), .rst(rst), .bus(bus1));
  dmem_responder #(.BASE_ADDR(B), .DEPTH(4096), .WAIT_STATES(2)) u_ws2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request on instance d; lat counts edges from the valid-sampling edge to the pulse.
  task automatic txn(input int d, input logic [31:0] a, input logic [31:0] w,
                     input logic [3:0] s, output int lat, output logic [31:0] rd,
                     output logic er);
    @(negedge clk);
    v[d] = 1'b1; ins[d] = a[4]; ad[d] = a; wd[d] = w; st[d] = s;
    lat = -1; rd = '0; er = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (rdy[d]) begin
        lat = i; rd = rdat[d]; er = err[d];
        break;
      end
    end
    v[d] = 1'b0;
    @(posedge clk); #1;
    check($sformatf("d%0d ready after pulse", d), 32'(rdy[d]), 32'h0);
    check($sformatf("d%0d rdata|error after pulse", d), rdat[d] | 32'(err[d]), 32'h0);
  endtask

  typedef struct {
    int          d;
    logic [31:0] a;
    logic [31:0] w;
    logic [3:0]  s;
    int          lat;
    logic [31:0] rd;
    logic        er;
  } vec_t;

  vec_t        tbl [18];
  int          lat;
  logic [31:0] rd;
  logic        er;
  int          np, p1, p2;
  logic [31:0] pr;

  initial begin
    for (int k = 0; k < 3; k++) begin
      v[k] = 1'b0; ins[k] = 1'b0; ad[k] = '0; wd[k] = '0; st[k] = '0;
    end

    tbl[0]  = '{0, B,             32'hDEADBEEF, 4'hF, 2, 32'h0,        1'b0};
    tbl[1]  = '{0, B,             32'h0,        4'h0, 2, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{0, B + 32'h8,     32'h11223344, 4'hF, 2, 32'h0,        1'b0};
    tbl[3]  = '{0, B + 32'h8,     32'hAA000000, 4'h8, 2, 32'h0,        1'b0};
    tbl[4]  = '{0, B + 32'h8,     32'h0000BB00, 4'h2, 2, 32'h0,        1'b0};
    tbl[5]  = '{0, B + 32'h8,     32'h0,        4'h0, 2, 32'hAA22BB44, 1'b0};
    tbl[6]  = '{0, B + 32'h4000,  32'h0,        4'h0, 2, 32'h0,        1'b1};
    tbl[7]  = '{0, B + 32'h3FFC,  32'hCAFEF00D, 4'hF, 2, 32'h0,        1'b0};
    tbl[8]  = '{0, B - 32'h4,     32'h12345678, 4'hF, 2, 32'h0,        1'b1};
    tbl[9]  = '{0, B + 32'h3FFC,  32'h0,        4'h0, 2, 32'hCAFEF00D, 1'b0};
    tbl[10] = '{0, B + 32'hA,     32'h0,        4'h0, 2, 32'hAA22BB44, 1'b0};
    tbl[11] = '{0, 32'h0,         32'h0,        4'h0, 2, 32'h0,        1'b1};
    tbl[12] = '{0, B + 32'h4000,  32'hFFFFFFFF, 4'hF, 2, 32'h0,        1'b1};
    tbl[13] = '{0, B,             32'h0,        4'h0, 2, 32'hDEADBEEF, 1'b0};
    tbl[14] = '{1, B + 32'h10,    32'h0BADCAFE, 4'hF, 5, 32'h0,        1'b0};
    tbl[15] = '{1, B + 32'h10,    32'h0,        4'h0, 5, 32'h0BADCAFE, 1'b0};
    tbl[16] = '{2, B + 32'h14,    32'h00000777, 4'hF, 4, 32'h0,        1'b0};
    tbl[17] = '{2, B + 32'h14,    32'h0,        4'h0, 4, 32'h00000777, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset d%0d ready", k), 32'(rdy[k]), 32'h0);
      check($sformatf("reset d%0d error", k), 32'(err[k]), 32'h0);
      check($sformatf("reset d%0d rdata", k), rdat[k], 32'h0);
    end
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      txn(tbl[i].d, tbl[i].a, tbl[i].w, tbl[i].s, lat, rd, er);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].lat));
      check($sformatf("vec%0d rdata", i), rd, tbl[i].rd);
      check($sformatf("vec%0d error", i), 32'(er), 32'(tbl[i].er));
    end

    // Valid held across two reads on the 3-wait-state instance
    np = 0; p1 = -1; p2 = -1; pr = '0;
    @(negedge clk);
    v[1] = 1'b1; ad[1] = B + 32'h10; st[1] = 4'h0;
    for (int i = 1; i <= 13; i++) begin
      @(posedge clk); #1;
      if (rdy[1]) begin
        np++;
        if (np == 1) begin p1 = i; pr = rdat[1]; end
        else if (np == 2) p2 = i;
      end
    end
    v[1] = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rdy[1]) np++;
    end
    check("held-valid pulse count", 32'(np), 32'd2);
    check("held-valid first pulse", 32'(p1), 32'd5);
    check("held-valid second pulse", 32'(p2), 32'd11);
    check("held-valid rdata", pr, 32'h0BADCAFE);

    // Abort in the first wait cycle
    np = 0;
    @(negedge clk);
    v[2] = 1'b1; ad[2] = B + 32'h14; wd[2] = 32'h55; st[2] = 4'hF;
    @(posedge clk); #1;
    v[2] = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rdy[2]) np++;
    end
    check("abort pulse count", 32'(np), 32'd0);
    txn(2, B + 32'h14, 32'h0, 4'h0, lat, rd, er);
    check("abort readback latency", 32'(lat), 32'd4);
    check("abort readback rdata", rd, 32'h00000777);

    // Reset while waiting
    np = 0;
    @(negedge clk);
    v[2] = 1'b1; ad[2] = B + 32'h14; wd[2] = 32'h99; st[2] = 4'hF;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    if (rdy[2]) np++;
    v[2] = 1'b0;
    @(posedge clk); #1;
    if (rdy[2]) np++;
    rst = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (rdy[2]) np++;
    end
    check("reset-mid pulse count", 32'(np), 32'd0);
    txn(2, B + 32'h14, 32'h0, 4'h0, lat, rd, er);
    check("reset-mid readback latency", 32'(lat), 32'd4);
    check("reset-mid readback rdata", rd, 32'h00000777);
    check("reset-mid readback error", 32'(er), 32'h0);
    txn(0, B, 32'h0, 4'h0, lat, rd, er);
    check("ram kept over reset latency", 32'(lat), 32'd2);
    check("ram kept over reset rdata", rd, 32'hDEADBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
